// File: rtl/bipolar_stream_gen.sv
// Encodes a signed WIDTH-bit value as a 2^WIDTH-bit bipolar unary stream.
// A bit-reversed position counter is the comparison source, so ones-count == offset exactly.
module bipolar_stream_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] IDX_LAST = '1;

  state_t           state;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] rng;
  logic [WIDTH-1:0] new_offset;
  logic             beat;
  logic             accept;

  always_comb begin
    rng = '0;
    for (int i = 0; i < WIDTH; i++) rng[i] = idx[WIDTH-1-i];
  end

  // Flipping the sign bit maps [-2^(W-1), 2^(W-1)) onto [0, 2^W).
  assign new_offset = {~in_value[WIDTH-1], in_value[WIDTH-2:0]};

  assign out_valid = (state == RUN);
  assign out_last  = out_valid && (idx == IDX_LAST);
  assign out_bit   = out_valid && (rng < offset);
  assign beat      = out_valid && out_ready;
  // clr blocks acceptance so in_ready never advertises a slot that will be dropped.
  assign in_ready  = !clr && ((state == IDLE) || (out_last && out_ready));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      offset <= '0;
    end else if (clr) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            offset <= new_offset;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            if (out_last) begin
              idx <= '0;
              if (accept) offset <= new_offset;
              else        state  <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bipolar_stream_gen.sv
// Directed bench for bipolar_stream_gen: exact ones-count, timing, backpressure, abort paths.
module tb_bipolar_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_bit, out_last;
  logic [7:0] in_value;

  int total = 0;
  int bad   = 0;
  int last_zero;

  bipolar_stream_gen #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Expected bit at stream position i for a given offset.
  function automatic logic mdl(input int i, input int off);
    logic [7:0] k, r;
    k = i[7:0];
    for (int j = 0; j < 8; j++) r[j] = k[7-j];
    return int'(r) < off;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic start(input logic [7:0] v, input string tag);
    in_valid = 1'b1;
    in_value = v;
    #1;
    chk({tag, "_acc_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_lat1_vld"}, out_valid, 1);
    chk({tag, "_busy_rdy"}, in_ready, 0);
  endtask

  // abort_kind: 0 none, 1 clr, 2 reset, triggered when position stop_at is presented.
  task automatic collect(input int exp_off, input bit stall, input int stop_at,
                         input int abort_kind, input bit b2b, input logic [7:0] nxt,
                         input string tag);
    int   idx = 0, cyc = 0, n_ones = 0, n_last = 0;
    int   bad_bit = 0, bad_last = 0, bad_hold = 0;
    bit   stalled = 0, done = 0;
    logic held_bit = 1'b0;
    last_zero = -1;
    while (!done && cyc < 3000) begin
      cyc++;
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (!out_valid) begin
        chk({tag, "_vld_drop"}, out_valid, 1);
        done = 1;
      end else if (idx == stop_at) begin
        out_ready = 1'b1;
        if (abort_kind == 1) begin
          clr = 1'b1; in_valid = 1'b1; in_value = 8'h7F;
        end else begin
          rst_n = 1'b0;
        end
        @(negedge clk);
        clr = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk({tag, "_abort_vld"}, out_valid, 0);
        chk({tag, "_abort_last"}, out_last, 0);
        chk({tag, "_abort_rdy"}, in_ready, 1);
        @(negedge clk);
        #1;
        chk({tag, "_abort_noacc"}, out_valid, 0);
        chk({tag, "_abort_nlast"}, n_last, 0);
        chk({tag, "_abort_bits"}, bad_bit, 0);
        done = 1;
      end else begin
        if (stalled && out_bit !== held_bit) bad_hold++;
        if (out_last !== (idx == 255)) bad_last++;
        if (out_ready) begin
          if (out_bit !== mdl(idx, exp_off)) bad_bit++;
          n_ones += int'(out_bit);
          n_last += int'(out_last);
          if (!out_bit) last_zero = idx;
          if (b2b && idx == 255) begin
            in_valid = 1'b1;
            in_value = nxt;
            #1;
            chk({tag, "_b2b_rdy"}, in_ready, 1);
          end
          idx++;
          stalled = 0;
          if (idx == 256) done = 1;
        end else begin
          stalled  = 1;
          held_bit = out_bit;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    if (!done) chk({tag, "_timeout"}, idx, 256);
    if (abort_kind == 0) begin
      chk({tag, "_ones"}, n_ones, exp_off);
      chk({tag, "_nlast"}, n_last, 1);
      chk({tag, "_bitseq"}, bad_bit, 0);
      chk({tag, "_lastpos"}, bad_last, 0);
      chk({tag, "_hold"}, bad_hold, 0);
      #1;
      if (b2b) begin
        chk({tag, "_nobubble"}, out_valid, 1);
      end else begin
        chk({tag, "_idle_vld"}, out_valid, 0);
        chk({tag, "_idle_rdy"}, in_ready, 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_value = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // value 0 -> offset 128, alternating 1,0,...
    start(8'h00, "zero");
    collect(128, 0, -1, 0, 0, 8'h00, "zero");
    start(8'h80, "neg1");
    collect(0, 0, -1, 0, 0, 8'h00, "neg1");
    start(8'h7F, "max");
    collect(255, 0, -1, 0, 0, 8'h00, "max");
    chk("max_zero_at", last_zero, 255);
    start(8'h40, "p64");
    collect(192, 0, -1, 0, 0, 8'h00, "p64");

    // A second offer while busy must not be consumed.
    start(8'h00, "acc");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_value  = 8'h7F;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("acc_busy_rdy", in_ready, 0);
      chk("acc_stall_bit", out_bit, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect(128, 0, -1, 0, 0, 8'h00, "acc");

    start(8'h00, "bp");
    collect(128, 1, -1, 0, 0, 8'h00, "bp");

    // Back-to-back: -64 -> offset 64.
    start(8'h00, "b2b");
    collect(128, 0, -1, 0, 1, 8'hC0, "b2b_a");
    collect(64, 0, -1, 0, 0, 8'h00, "b2b_b");

    start(8'h00, "clr");
    collect(128, 0, 100, 1, 0, 8'h00, "clr");
    start(8'h40, "rst");
    collect(192, 0, 50, 2, 0, 8'h00, "rst");
    // -1 -> offset 127
    start(8'hFF, "post");
    collect(127, 0, -1, 0, 0, 8'h00, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bipolar_stream_gen.md
Name: bipolar_stream_gen

Overview:
- Converts a two's-complement binary value into a bipolar unary bitstream for the unary kernels.
- Bipolar meaning: P(bit=1) = (value/2^(WIDTH-1) + 1)/2.
- This is the encode end of the bipolar stream path; downstream sign/counter decoders consume the stream.
- Uses a bit-reversed counter as the deterministic low-discrepancy source, so the ones-count over one full stream is exact.
- Valid/ready on both sides; one stream of 2^WIDTH bits per accepted value.

Parameters:
- WIDTH, 8, width of the signed input value; stream length is 2^WIDTH bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- clr  input  1  synchronous abort: drop the current stream, return to IDLE
- in_valid  input  1  in_value is offered
- in_ready  output  1  block can accept a value this cycle
- in_value  input  WIDTH  signed two's-complement source value
- out_valid  output  1  out_bit is valid
- out_ready  input  1  consumer accepts out_bit this cycle
- out_bit  output  1  current stream bit
- out_last  output  1  marks the final bit (index 2^WIDTH-1) of the stream

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, idx=0, offset=0.
  - Outputs: in_ready=1, out_valid=0, out_bit=0, out_last=0.
  - rst_n has priority over clr, which has priority over everything else.
- Registers:
  - offset[WIDTH-1:0] = in_value with MSB inverted, i.e. in_value + 2^(WIDTH-1), unsigned.
  - idx[WIDTH-1:0] = stream position.
- Combinational outputs:
  - rng = bit-reverse(idx).
  - out_bit = (rng < offset), unsigned compare, valid only while out_valid=1.
  - out_bit=0 when out_valid=0.
- Beat: out_valid & out_ready at a posedge.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid: load offset, idx=0, go RUN. First bit is presented the next cycle, so latency from accept to first out_valid is 1 cycle.
  - RUN: out_valid=1; out_last=(idx==2^WIDTH-1).
    - Beat with out_last=0: idx+1.
    - Beat with out_last=1: idx wraps to 0. If in_valid is also high that cycle, load the new offset and stay in RUN (back-to-back, no bubble). Otherwise go to IDLE.
    - No beat: idx, offset and out_bit hold stable (backpressure).
- in_ready = IDLE, or (RUN & out_last & out_ready).
- in_value is ignored when in_ready=0.
- Exactness: over one full stream the number of ones equals offset exactly. Achievable range is offset 0..2^WIDTH-1, i.e. value -1.0 to +(1-2^-(WIDTH-1)); +1.0 is not representable.
- clr:
  - In RUN: next cycle state=IDLE, idx=0, out_valid=0. No out_last is emitted, and a concurrent in_valid is not accepted.
  - In IDLE: no effect except that a concurrent in_valid is not accepted.
- Reset mid-stream: the same as clr, plus all registers return to their reset values.

Test Plan:
- WIDTH=8, in_value=0 (offset 128), out_ready=1 -> bits 1,0,1,0... for 256 beats, 128 ones total, out_last only on beat 255, then IDLE with in_ready=1.
- in_value=-128 -> 256 zeros. in_value=127 -> 255 ones, with the single 0 at idx 255. in_value=64 (offset 192) -> exactly 192 ones.
- Accept timing: in_valid held for 1 cycle in IDLE -> in_ready drops the next cycle, out_valid rises exactly 1 cycle after accept, and a second in_valid while running is not consumed.
- Backpressure: in_value=0, toggle out_ready pseudo-randomly -> out_bit stable while stalled, sequence identical to the no-stall run, 128 ones, exactly one out_last.
- Back-to-back: present in_value=-64 during the last beat of an in_value=0 stream -> no idle cycle; next stream starts at idx 0 with 64 ones.
- clr at idx 100, then rst_n low at idx 50 of a new stream -> each returns to IDLE the next posedge, out_valid=0, and no out_last is seen. A subsequent stream is exact.
